uart_frame_scheduler: RTL and testbench
=======================================

Name: uart_frame_scheduler

Overview:
- Replaces the ad-hoc UART byte sequencing with a timed frame scheduler that shares the single UART TX FIFO among all 13 voltage channels.
- Every FRAME_PERIOD cycles it snapshots the 13 BCD readings: the internal ADC first, then 12 external ADC channels.
- It streams the snapshot as fixed-format ASCII lines into the UART write port, obeying the FIFO full flag.
- Sits between the ADC BCD outputs and the uart instance, in the clk_65MHz domain.

Parameters:
- NCH, 13, number of channels per frame.
- FRAME_PERIOD, 6500000, cycles between frame start requests (100 ms at 65 MHz).
- CNT_W, 23, width of the period counter; must satisfy 2^CNT_W > FRAME_PERIOD.

Ports:
- clk, input, 1, system clock (clk_65MHz).
- rst, input, 1, asynchronous active-low reset.
- enable, input, 1, periodic frame generation enable.
- ch_bcd, input, 16*NCH, channel k occupies bits [16k+15:16k]; 4 BCD digits D3.D2D1D0 volts, D3 in the MSB nibble.
- tx_full, input, 1, UART FIFO full.
- w_data, output, 8, byte to write.
- wr_uart, output, 1, single-cycle write strobe.
- busy, output, 1, frame in progress.
- frame_done, output, 1, single-cycle pulse after the last byte of a frame.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, period counter 0, pending 0, FSM in IDLE, snapshot registers 0.
- Period counter:
  - When enable=1 it increments each cycle.
  - At FRAME_PERIOD-1 it wraps to 0 and sets pending.
  - When enable=0 the counter is held at 0 and pending is cleared.
  - A frame already in progress always completes.
- Pending is a single flag: ticks arriving while busy set it once and do not queue further; a tick in the same cycle pending is consumed still leaves pending=1.
- FSM states:
  - IDLE: if pending, clear pending, go to LATCH.
  - LATCH: copy all of ch_bcd into the snapshot (1 cycle), set busy=1, ch=0, idx=0, go to SEND.
  - SEND: if tx_full=0, drive w_data = formatted byte(ch, idx) and wr_uart=1 for exactly one cycle, go to GAP. If tx_full=1, stay in SEND with wr_uart=0.
  - GAP: one cycle with wr_uart=0 so the registered FIFO full flag can update. Then advance idx. After idx 10, set idx=0 and ch+1. After the last byte of ch=NCH-1, go to DONE; otherwise return to SEND.
  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Line format, 11 bytes per channel, idx 0..10:
  - idx 0..1: tens and ones ASCII of ch, e.g. "07".
  - idx 2: ':'.
  - idx 3: ASCII of D3.
  - idx 4: '.'.
  - idx 5..7: ASCII of D2, D1, D0.
  - idx 8: 'V'.
  - idx 9: 0x0D (CR).
  - idx 10: 0x0A (LF).
- Frame length is NCH*11 = 143 bytes.
- BCD nibble > 9 is sent as '?' (0x3F).
- w_data is registered and holds its last value when wr_uart=0.
- Minimum spacing between writes is 2 cycles.
- Input changes after LATCH do not affect the frame in flight.
- Reset mid-frame aborts immediately with no partial recovery; the next frame starts from ch 0 after the next tick.

Decomposition:
- Shared package (voltmeter_pkg) holds:
  - ASCII constants (ASCII_0, COLON, DOT, VOLT, CR, LF, QMARK).
  - LINE_BYTES=11.
  - NCH default.
  - FSM state encoding.
- One sub-module, uart_line_formatter: combinational; inputs ch[3:0], idx[3:0], bcd[15:0]; output byte[7:0]. It encapsulates the format table and digit-to-ASCII conversion, including the '?' substitution.

Test Plan:
1. Reset, then FRAME_PERIOD=200, enable=1, tx_full=0, ch0=16'h3141, all others 16'h0000 -> first wr_uart at cycle ~202. First 11 bytes are "00:3.141V\r\n". Exactly 143 strobes, each separated by ≥1 idle cycle, then one frame_done pulse, busy=0.
2. ch12=16'h0A99 -> line 12 reads "12:0.?99V\r\n" (0x3F at idx 5).
3. tx_full held high for 50 cycles mid-frame (after byte 20) -> no strobes while full. Byte 21 is emitted after release, with no bytes lost or duplicated (total still 143).
4. ch_bcd changed during transmission -> the frame carries the values latched at LATCH. The next frame carries the new values.
5. enable dropped at byte 40 -> the frame completes (143 bytes), no further frames. Re-enable -> next frame starts 200 cycles later.
6. rst asserted low at byte 70 -> wr_uart, busy, and frame_done go to 0 asynchronously. After release, the next frame starts with "00:".

Source files
------------

// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter UART path: ASCII constants, line geometry,
// scheduler state encoding and the BCD digit to ASCII helper.
package voltmeter_pkg;

  localparam int NCH_DEFAULT = 13;
  localparam int LINE_BYTES  = 11;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] DOT     = 8'h2E;
  localparam logic [7:0] VOLT    = 8'h56;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;
  localparam logic [7:0] QMARK   = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } sched_state_t;

  // Nibbles above 9 are not valid BCD; they go out as '?' so the line length never changes.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    logic [7:0] c;
    if (d > 4'd9) c = QMARK;
    else          c = ASCII_0 + {4'd0, d};
    return c;
  endfunction

endpackage

// File: rtl/uart_line_formatter.sv
// Combinational byte generator for one channel line "CC:D.DDDV\r\n".
// idx selects the byte within the line; bcd holds D3..D0 with D3 in the top nibble.
module uart_line_formatter
  import voltmeter_pkg::*;
(
  input  logic [3:0]  ch,
  input  logic [3:0]  idx,
  input  logic [15:0] bcd,
  output logic [7:0]  ascii
);

  logic [3:0] tens;
  logic [3:0] ones;

  always_comb begin
    tens = 4'd0;
    ones = ch;
    if (ch >= 4'd10) begin
      tens = 4'd1;
      ones = ch - 4'd10;
    end
  end

  always_comb begin
    ascii = QMARK;
    case (idx)
      4'd0:    ascii = bcd_to_ascii(tens);
      4'd1:    ascii = bcd_to_ascii(ones);
      4'd2:    ascii = COLON;
      4'd3:    ascii = bcd_to_ascii(bcd[15:12]);
      4'd4:    ascii = DOT;
      4'd5:    ascii = bcd_to_ascii(bcd[11:8]);
      4'd6:    ascii = bcd_to_ascii(bcd[7:4]);
      4'd7:    ascii = bcd_to_ascii(bcd[3:0]);
      4'd8:    ascii = VOLT;
      4'd9:    ascii = CR;
      4'd10:   ascii = LF;
      default: ascii = QMARK;
    endcase
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Periodic frame scheduler: snapshots NCH BCD readings and streams them as ASCII
// lines into the UART TX FIFO write port, one byte every other cycle at most.
module uart_frame_scheduler
  import voltmeter_pkg::*;
#(
  parameter int NCH          = NCH_DEFAULT,
  parameter int FRAME_PERIOD = 6500000,
  parameter int CNT_W        = 23
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [16*NCH-1:0] ch_bcd,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic              busy,
  output logic              frame_done
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             tick;
  logic             pending_reg, pending_next;
  sched_state_t     state_reg, state_next;
  logic [3:0]       ch_reg, ch_next;
  logic [3:0]       idx_reg, idx_next;
  logic [7:0]       w_data_reg, w_data_next;
  logic             wr_reg, wr_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [16*NCH-1:0] snap_flat;
  logic [15:0]       cur_bcd;
  logic [7:0]        fmt_byte;

  // Per-channel snapshot words, loaded only in LATCH so the frame in flight is frozen.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_snap
      logic [15:0] word_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      word_reg <= '0;
        else if (state_reg == ST_LATCH) word_reg <= ch_bcd[16*gi +: 16];
      end
      assign snap_flat[16*gi +: 16] = word_reg;
    end
  endgenerate

  always_comb begin
    cur_bcd = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_reg == k[3:0]) cur_bcd = snap_flat[16*k +: 16];
    end
  end

  uart_line_formatter u_fmt (
    .ch    (ch_reg),
    .idx   (idx_reg),
    .bcd   (cur_bcd),
    .ascii (fmt_byte)
  );

  always_comb begin
    cnt_next = cnt_reg;
    tick     = 1'b0;
    if (!enable) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(FRAME_PERIOD - 1)) begin
      cnt_next = '0;
      tick     = 1'b1;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    ch_next      = ch_reg;
    idx_next     = idx_reg;
    w_data_next  = w_data_reg;
    wr_next      = 1'b0;
    busy_next    = busy_reg;
    done_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (pending_reg) begin
          pending_next = 1'b0;
          state_next   = ST_LATCH;
        end
      end
      ST_LATCH: begin
        busy_next  = 1'b1;
        ch_next    = '0;
        idx_next   = '0;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_full) begin
          wr_next     = 1'b1;
          w_data_next = fmt_byte;
          state_next  = ST_GAP;
        end
      end
      // The strobe is visible during GAP, giving the FIFO a cycle to raise full.
      ST_GAP: begin
        if (idx_reg == 4'(LINE_BYTES - 1)) begin
          idx_next = '0;
          if (ch_reg == 4'(NCH - 1)) begin
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = ST_DONE;
          end else begin
            ch_next    = ch_reg + 4'd1;
            state_next = ST_SEND;
          end
        end else begin
          idx_next   = idx_reg + 4'd1;
          state_next = ST_SEND;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A tick coinciding with consumption re-arms; disabling wins over both.
    if (tick)    pending_next = 1'b1;
    if (!enable) pending_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      state_reg   <= ST_IDLE;
      ch_reg      <= '0;
      idx_reg     <= '0;
      w_data_reg  <= '0;
      wr_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      state_reg   <= state_next;
      ch_reg      <= ch_next;
      idx_reg     <= idx_next;
      w_data_reg  <= w_data_next;
      wr_reg      <= wr_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign w_data     = w_data_reg;
  assign wr_uart    = wr_reg;
  assign busy       = busy_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a short frame period; byte stream
// is captured on the falling edge and checked against hand-built ASCII lines.
module tb_uart_frame_scheduler;

  localparam int NCH = 13;
  localparam int FB  = NCH * 11;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [16*NCH-1:0] ch_bcd;
  logic              tx_full;
  logic [7:0]        w_data;
  logic              wr_uart;
  logic              busy;
  logic              frame_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] bytes[$];
  int         times[$];
  int         done_cnt    = 0;
  int         spacing_err = 0;
  logic       prev_wr     = 1'b0;

  uart_frame_scheduler #(
    .NCH          (NCH),
    .FRAME_PERIOD (200),
    .CNT_W        (23)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ch_bcd     (ch_bcd),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (wr_uart) begin
        bytes.push_back(w_data);
        times.push_back(cyc);
        if (prev_wr) spacing_err++;
      end
      if (frame_done) done_cnt++;
      prev_wr = wr_uart;
    end else begin
      prev_wr = 1'b0;
    end
  end

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] digit(input logic [3:0] d);
    logic [7:0] c;
    c = (d > 4'd9) ? 8'h3F : (8'h30 + {4'd0, d});
    return c;
  endfunction

  function automatic logic [87:0] exp_line(input int ch, input logic [15:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(ch / 10);
    o = 4'(ch % 10);
    return {digit(t), digit(o), ":", digit(v[15:12]), ".", digit(v[11:8]),
            digit(v[7:4]), digit(v[3:0]), "V", 8'h0D, 8'h0A};
  endfunction

  function automatic logic [87:0] line_at(input int base);
    logic [87:0] v;
    v = 'x;
    if (base + 11 <= bytes.size()) begin
      for (int i = 0; i < 11; i++) v = {v[79:0], bytes[base + i]};
    end
    return v;
  endfunction

  task automatic set_ch(input int k, input logic [15:0] v);
    ch_bcd[16*k +: 16] = v;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (bytes.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check_int(tag, int'(bytes.size() >= n), 1);
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check_int(tag, done_cnt, n);
  endtask

  int c0;
  int base;

  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    tx_full = 1'b0;
    ch_bcd  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_int("rst_wr_uart", int'(wr_uart), 0);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_frame_done", int'(frame_done), 0);
    check_int("rst_w_data", int'(w_data), 0);

    // Frame 1: nominal line contents, '?' substitution, enable dropped at byte 40
    set_ch(0, 16'h3141);
    set_ch(12, 16'h0A99);
    rst    = 1'b1;
    enable = 1'b1;
    c0     = cyc;
    wait_bytes("f1_first_strobe", 1, 400);
    check_int("f1_first_latency", times[0] - c0, 203);
    check_int("f1_busy_high", int'(busy), 1);
    wait_bytes("f1_byte40", 40, 200);
    enable = 1'b0;
    wait_done("f1_done", 1, 600);
    check_int("f1_busy_low", int'(busy), 0);
    check_int("f1_count", bytes.size(), FB);
    check_vec("f1_line0", line_at(0), exp_line(0, 16'h3141));
    check_vec("f1_line5", line_at(55), exp_line(5, 16'h0000));
    check_vec("f1_line12", line_at(132), exp_line(12, 16'h0A99));
    repeat (300) @(negedge clk);
    #1;
    check_int("f1_no_more_bytes", bytes.size(), FB);
    check_int("f1_no_more_done", done_cnt, 1);

    // Frame 2: re-enable latency, full stall after byte 20, inputs changed mid-frame
    enable = 1'b1;
    c0     = cyc;
    wait_bytes("f2_first_strobe", FB + 1, 400);
    check_int("f2_first_latency", times[FB] - c0, 203);
    wait_bytes("f2_byte20", FB + 20, 200);
    tx_full = 1'b1;
    set_ch(0, 16'h9999);
    set_ch(3, 16'hF00C);
    set_ch(5, 16'h5555);
    set_ch(12, 16'h1234);
    repeat (50) @(negedge clk);
    #1;
    check_int("f2_stall_no_bytes", bytes.size(), FB + 20);
    tx_full = 1'b0;
    wait_done("f2_done", 2, 1000);
    check_int("f2_count", bytes.size(), 2 * FB);
    check_int("f2_byte21_cr", int'(bytes[FB + 20]), 8'h0D);
    check_vec("f2_line1", line_at(FB + 11), exp_line(1, 16'h0000));
    check_vec("f2_line5_old", line_at(FB + 55), exp_line(5, 16'h0000));
    check_vec("f2_line12_old", line_at(FB + 132), exp_line(12, 16'h0A99));

    // Frame 3 follows from the tick that arrived while busy and carries the new values
    wait_bytes("f3_first_strobe", 2 * FB + 1, 100);
    enable = 1'b0;
    wait_done("f3_done", 3, 800);
    check_vec("f3_line0", line_at(2 * FB), exp_line(0, 16'h9999));
    check_vec("f3_line3", line_at(2 * FB + 33), exp_line(3, 16'hF00C));
    check_vec("f3_line5", line_at(2 * FB + 55), exp_line(5, 16'h5555));
    check_vec("f3_line12", line_at(2 * FB + 132), exp_line(12, 16'h1234));
    repeat (300) @(negedge clk);
    #1;
    check_int("f3_no_more_bytes", bytes.size(), 3 * FB);

    // Frame 4: asynchronous reset while a strobe is high, then restart from channel 0
    enable = 1'b1;
    wait_bytes("f4_byte70", 3 * FB + 70, 800);
    #1;
    check_int("f4_pre_reset_strobe", int'(wr_uart), 1);
    rst = 1'b0;
    #1;
    check_int("f4_async_wr_uart", int'(wr_uart), 0);
    check_int("f4_async_busy", int'(busy), 0);
    check_int("f4_async_frame_done", int'(frame_done), 0);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    base = bytes.size();
    wait_bytes("f5_first3", base + 3, 400);
    check_int("f5_byte0", int'(bytes[base]), 8'h30);
    check_int("f5_byte1", int'(bytes[base + 1]), 8'h30);
    check_int("f5_byte2", int'(bytes[base + 2]), 8'h3A);
    check_int("strobe_spacing", spacing_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
